// File: rtl/dpa_core_arbiter.sv
// dpa_core_arbiter
//   Shares one masked Skinny primitive between two requesters:
//   requester 0 (initial key derivation) and requester 1 (tag finalization).
//   An accepted request has its operands latched, the core gets a one-cycle
//   start, and the registered D-share result goes back to the owner over
//   valid/ready. A watchdog bounds the wait for core_done; expiry parks the
//   block in a sticky error state that only reset clears.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   key                 masked key (KEY_SIZE*D), sampled at grant
//   req_valid/ready     per-requester request handshake (ready one-hot or 0)
//   req_tk1/tk2         per-requester TK1/TK2, requester 0 in the low half
//   req_state           per-requester masked state, requester 0 in the low half
//   rsp_valid/ready     per-requester result handshake (valid one-hot)
//   rsp_data            registered masked result, shared by both requesters
//   core_*              interface to the masked primitive
//   busy                high in every state except IDLE
//   error               sticky watchdog-expiry flag
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no owner; round-robin grant offered combinationally
// ISSUE  | one-cycle core_start, watchdog cleared
// WAIT   | core running; watchdog counting; done captures the result
// RESP   | result held on rsp_data until the owner accepts it
// ERR    | watchdog expired; core held in reset; left only by rst

module dpa_core_arbiter #(
  parameter int D        = 2,
  parameter int BLK_SIZE = 128,
  parameter int KEY_SIZE = 128,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 8     // 2**CNT_W must exceed TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KEY_SIZE*D-1:0]     key,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*BLK_SIZE-1:0]     req_tk1,
  input  logic [2*BLK_SIZE-1:0]     req_tk2,
  input  logic [2*BLK_SIZE*D-1:0]   req_state,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [BLK_SIZE*D-1:0]     rsp_data,
  output logic                      core_start,
  output logic                      core_reset,
  output logic [BLK_SIZE-1:0]       core_tk1,
  output logic [BLK_SIZE-1:0]       core_tk2,
  output logic [KEY_SIZE*D-1:0]     core_key,
  output logic [BLK_SIZE*D-1:0]     core_state_in,
  input  logic [BLK_SIZE*D-1:0]     core_state_out,
  input  logic                      core_done,
  output logic                      busy,
  output logic                      error
);

  localparam int SW = BLK_SIZE * D;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner;
  logic                  r_last_grant;
  logic [CNT_W-1:0]      r_wd;
  logic [BLK_SIZE-1:0]   r_tk1;
  logic [BLK_SIZE-1:0]   r_tk2;
  logic [KEY_SIZE*D-1:0] r_key;
  logic [SW-1:0]         r_state_in;
  logic [SW-1:0]         r_rsp_data;

  logic [1:0]            w_grant;
  logic [1:0]            w_ready;
  logic                  w_take;
  logic                  w_capture;
  logic                  w_wd_hit;

  // Round-robin: on a tie the requester that did not win last time gets it.
  // r_last_grant resets to 1 so requester 0 wins the first tie.
  always_comb begin
    w_grant = 2'b00;
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_wd_hit = (r_wd == CNT_W'(TIMEOUT));

  always_comb begin
    w_next     = r_state;
    w_ready    = 2'b00;
    w_take     = 1'b0;
    w_capture  = 1'b0;
    core_start = 1'b0;
    core_reset = 1'b1;
    rsp_valid  = 2'b00;
    case (r_state)
      S_IDLE: begin
        // rst gating keeps req_ready low while reset is held, even though
        // the grant itself is purely combinational from req_valid.
        if (rst) w_ready = w_grant;
        if (|(req_valid & w_ready)) begin
          w_take = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_reset = 1'b0;
        core_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        core_reset = 1'b0;
        // done has priority over a watchdog hit in the same cycle
        if (core_done) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (w_wd_hit) begin
          w_next = S_ERR;
        end
      end
      S_RESP: begin
        rsp_valid = r_owner ? 2'b10 : 2'b01;
        if (rsp_ready[r_owner]) w_next = S_IDLE;
      end
      S_ERR: begin
        w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_tk1        <= '0;
      r_tk2        <= '0;
      r_key        <= '0;
      r_state_in   <= '0;
    end else if (w_take) begin
      r_owner      <= w_grant[1];
      r_last_grant <= w_grant[1];
      r_tk1        <= w_grant[1] ? req_tk1[2*BLK_SIZE-1:BLK_SIZE] : req_tk1[BLK_SIZE-1:0];
      r_tk2        <= w_grant[1] ? req_tk2[2*BLK_SIZE-1:BLK_SIZE] : req_tk2[BLK_SIZE-1:0];
      r_key        <= key;
      r_state_in   <= w_grant[1] ? req_state[2*SW-1:SW] : req_state[SW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // Result is always registered: no path from core_state_out to rsp_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_rsp_data <= '0;
    else if (w_capture) r_rsp_data <= core_state_out;
  end

  assign req_ready     = w_ready;
  assign rsp_data      = r_rsp_data;
  assign core_tk1      = r_tk1;
  assign core_tk2      = r_tk2;
  assign core_key      = r_key;
  assign core_state_in = r_state_in;
  assign busy          = (r_state != S_IDLE);
  assign error         = (r_state == S_ERR);

endmodule

// File: tb/tb_dpa_core_arbiter.sv
module tb_dpa_core_arbiter;

  localparam int D  = 2;
  localparam int B  = 128;
  localparam int K  = 128;
  localparam int SW = B * D;

  localparam logic [B-1:0]   PUB    = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [SW-1:0]  NONCE  = 256'hdead_beef_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd;
  localparam logic [K*D-1:0] KEYV   = 256'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100_f0e0_d0c0_b0a0_9080_7060_5040_3020_1000;
  localparam logic [SW-1:0]  RES0   = 256'h1357_9bdf_2468_ace0_1357_9bdf_2468_ace0_5a5a_5a5a_a5a5_a5a5_c3c3_c3c3_3c3c_3c3c;
  localparam logic [SW-1:0]  RES1   = 256'h0000_0000_0000_0000_0000_0000_0000_0001_8000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [SW-1:0]  RES2   = 256'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_0000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [SW-1:0]  RES3   = 256'h0123_0123_0123_0123_4567_4567_4567_4567_89ab_89ab_89ab_89ab_cdef_cdef_cdef_cdef;
  localparam logic [SW-1:0]  RES4   = 256'h7777_6666_5555_4444_3333_2222_1111_0000_7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [SW-1:0]  RES5   = 256'h2b7e_1516_28ae_d2a6_abf7_1588_09cf_4f3c_3243_f6a8_885a_308d_3131_98a2_e037_0734;
  localparam logic [SW-1:0]  JUNK   = 256'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
  localparam logic [B-1:0]   T1_R0  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [B-1:0]   T1_R1  = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;

  logic              clk = 1'b0;
  logic              rst;
  logic [K*D-1:0]    key;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*B-1:0]    req_tk1;
  logic [2*B-1:0]    req_tk2;
  logic [2*SW-1:0]   req_state;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [SW-1:0]     rsp_data;
  logic              core_start;
  logic              core_reset;
  logic [B-1:0]      core_tk1;
  logic [B-1:0]      core_tk2;
  logic [K*D-1:0]    core_key;
  logic [SW-1:0]     core_state_in;
  logic [SW-1:0]     core_state_out;
  logic              core_done;
  logic              busy;
  logic              error;

  int n_cmp = 0;
  int n_mis = 0;

  dpa_core_arbiter #(.D(D), .BLK_SIZE(B), .KEY_SIZE(K), .TIMEOUT(255), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .key(key),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tk1(req_tk1), .req_tk2(req_tk2), .req_state(req_state),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .core_start(core_start), .core_reset(core_reset),
    .core_tk1(core_tk1), .core_tk2(core_tk2), .core_key(core_key),
    .core_state_in(core_state_in), .core_state_out(core_state_out),
    .core_done(core_done), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  // One full operation with req_valid held by the caller: grant, start,
  // done after a few WAIT cycles, optional backpressure, then accept.
  task automatic do_op(input int ow, input logic [B-1:0] exp_tk1,
                       input logic [SW-1:0] res, input int bp);
    logic [1:0] oh;
    int bad;
    oh = (ow != 0) ? 2'b10 : 2'b01;
    #1;
    chk("op_grant", req_ready, oh);
    tick;
    chk("op_start", core_start, 1'b1);
    chk("op_tk1", core_tk1, exp_tk1);
    tick;
    tick;
    tick;
    core_done = 1'b1;
    core_state_out = res;
    tick;
    core_done = 1'b0;
    core_state_out = JUNK;
    chk("op_rsp_valid", rsp_valid, oh);
    chk("op_rsp_data", rsp_data, res);
    bad = 0;
    rsp_ready = ~oh;
    for (int i = 0; i < bp; i++) begin
      tick;
      if (rsp_valid !== oh || rsp_data !== res || req_ready !== 2'b00) bad++;
    end
    if (bp > 0) chk("op_backpressure", bad, 0);
    rsp_ready = oh;
    tick;
    rsp_ready = 2'b00;
    chk("op_done_idle", busy, 1'b0);
  endtask

  initial begin
    int starts;
    int bad;

    rst            = 1'b0;
    key            = '0;
    req_valid      = 2'b00;
    req_tk1        = '0;
    req_tk2        = '0;
    req_state      = '0;
    rsp_ready      = 2'b00;
    core_state_out = '0;
    core_done      = 1'b0;

    // Reset values
    tick;
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    req_valid = 2'b00;
    tick;
    rst = 1'b1;

    // Dropping req_valid before the handshake: no transfer
    tick;
    req_valid = 2'b01;
    #1;
    chk("drop_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    tick;
    chk("drop_busy", busy, 1'b0);

    // Requester 0 alone: key derivation, done after ~40 cycles
    req_tk1   = {T1_R1, 128'h0};
    req_tk2   = {128'h0, PUB};
    req_state = {JUNK, NONCE};
    key       = KEYV;
    req_valid = 2'b01;
    #1;
    chk("r0_ready", req_ready, 2'b01);
    tick;
    chk("r0_start", core_start, 1'b1);
    chk("r0_core_reset", core_reset, 1'b0);
    chk("r0_tk1", core_tk1, 128'h0);
    chk("r0_tk2", core_tk2, PUB);
    chk("r0_state_in", core_state_in, NONCE);
    chk("r0_key", core_key, KEYV);
    req_valid = 2'b00;
    req_tk2   = '1;
    req_state = '1;
    key       = '0;
    starts = 0;
    for (int i = 0; i < 39; i++) begin
      tick;
      if (core_start === 1'b1) starts++;
    end
    chk("r0_single_start", starts, 0);
    chk("r0_tk2_held", core_tk2, PUB);
    chk("r0_key_held", core_key, KEYV);
    core_done = 1'b1;
    core_state_out = RES0;
    tick;
    core_done = 1'b0;
    core_state_out = JUNK;
    #1;
    chk("r0_rsp_valid", rsp_valid, 2'b01);
    chk("r0_rsp_data", rsp_data, RES0);
    chk("r0_resp_core_reset", core_reset, 1'b1);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    chk("r0_idle_busy", busy, 1'b0);
    chk("r0_idle_rsp_valid", rsp_valid, 2'b00);

    // Both requesters held: round-robin 0,1,0 after reset; backpressure on third
    do_reset;
    req_tk1   = {T1_R1, T1_R0};
    req_valid = 2'b11;
    do_op(0, T1_R0, RES1, 0);
    do_op(1, T1_R1, RES2, 0);
    do_op(0, T1_R0, RES3, 10);
    req_valid = 2'b00;

    // Watchdog: done never arrives. WAIT cycles carry watchdog 0..255,
    // ERR follows the WAIT cycle in which the watchdog equals 255.
    req_valid = 2'b10;
    #1;
    tick;
    req_valid = 2'b00;
    tick;
    for (int i = 0; i < 255; i++) tick;
    chk("wd_before_error", error, 1'b0);
    chk("wd_before_busy", busy, 1'b1);
    tick;
    chk("wd_error", error, 1'b1);
    req_valid = 2'b11;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (req_ready !== 2'b00 || error !== 1'b1 || rsp_valid !== 2'b00 || core_reset !== 1'b1) bad++;
    end
    chk("wd_sticky", bad, 0);
    req_valid = 2'b00;
    do_reset;
    chk("wd_cleared", error, 1'b0);

    // core_done coincides with watchdog reaching 255: done wins
    req_valid = 2'b01;
    #1;
    tick;
    req_valid = 2'b00;
    tick;
    for (int i = 0; i < 255; i++) tick;
    core_done = 1'b1;
    core_state_out = RES5;
    tick;
    core_done = 1'b0;
    chk("tie_rsp_valid", rsp_valid, 2'b01);
    chk("tie_error", error, 1'b0);
    chk("tie_rsp_data", rsp_data, RES5);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;

    // Reset during WAIT, then a fresh request from requester 1
    req_valid = 2'b01;
    key = KEYV;
    #1;
    tick;
    req_valid = 2'b00;
    tick;
    tick;
    tick;
    rst = 1'b0;
    req_valid = 2'b10;
    #1;
    chk("abort_core_reset", core_reset, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_key_cleared", core_key, '0);
    chk("abort_req_ready", req_ready, 2'b00);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      if (rsp_valid !== 2'b00 || core_reset !== 1'b1) bad++;
    end
    rst = 1'b1;
    #1;
    chk("abort_quiet", bad, 0);
    chk("fresh_ready", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    chk("fresh_start", core_start, 1'b1);
    chk("fresh_tk1", core_tk1, T1_R1);
    tick;
    core_done = 1'b1;
    core_state_out = RES4;
    tick;
    core_done = 1'b0;
    chk("fresh_rsp_valid", rsp_valid, 2'b10);
    chk("fresh_rsp_data", rsp_data, RES4);
    rsp_ready = 2'b10;
    tick;
    rsp_ready = 2'b00;
    chk("fresh_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
